pc_gen_unit: RTL and testbench

- Parametrised program-counter generator for the RISC-V core; it replaces the fixed combinational PC+4 incrementer.
- Holds the architectural PC register and computes the sequential next PC: +2 for compressed instructions, +4 otherwise.
- Arbitrates the next PC between trap, redirect (branch/jump), stall and sequential increment.
- Runs a boot/run/halt state machine, flags misaligned redirect targets and counts PC advances for performance monitoring.

---
 rtl/pc_gen_unit.sv | 117 +++++++++++
 tb/tb_pc_gen_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: program-counter generator with boot/run/halt control.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   stall_i, is_compressed_i        hold request, 16-bit instruction flag
//   redirect_i, redirect_target_i   taken branch/jump and its target
//   trap_i, trap_vector_i           trap taken and handler base
//   halt_i, resume_i                enter / leave HALT
//   pc_o, pc_plus_o                 current PC and its sequential successor
//   pc_valid_o                      high while in RUN
//   misaligned_o, misaligned_addr_o one-cycle reject pulse, last rejected target
//   fetch_count_o                   number of PC advances (wrapping)
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BOOT_WAIT    = 2,
    parameter bit              ALLOW_C      = 1'b1,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             is_compressed_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             trap_i,
    input  logic [XLEN-1:0]  trap_vector_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus_o,
    output logic             pc_valid_o,
    output logic             misaligned_o,
    output logic [XLEN-1:0]  misaligned_addr_o,
    output logic [CNT_W-1:0] fetch_count_o
);
    localparam int BW = $clog2(BOOT_WAIT + 1);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t            state_q;
    logic [BW-1:0]     boot_cnt_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   mis_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;
    logic              mis_q;
    logic              legal;
    logic [XLEN-1:0]   trap_pc;

    assign pc_plus_o = pc_q + ((ALLOW_C && is_compressed_i) ? XLEN'(2) : XLEN'(4));
    assign legal     = ALLOW_C ? ~redirect_target_i[0] : (redirect_target_i[1:0] == 2'b00);
    assign trap_pc   = {trap_vector_i[XLEN-1:2], 2'b00};

    assign pc_o              = pc_q;
    assign pc_valid_o        = valid_q;
    assign misaligned_o      = mis_q;
    assign misaligned_addr_o = mis_addr_q;
    assign fetch_count_o     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            pc_q       <= RESET_VECTOR;
            mis_addr_q <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            mis_q <= 1'b0;
            if (trap_i) begin
                // a trap wins in every state and always lands in RUN
                pc_q    <= trap_pc;
                cnt_q   <= cnt_q + CNT_W'(1);
                state_q <= RUN;
                valid_q <= 1'b1;
            end else begin
                case (state_q)
                    BOOT: begin
                        if (boot_cnt_q == BW'(BOOT_WAIT - 1)) begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                        end else begin
                            boot_cnt_q <= boot_cnt_q + BW'(1);
                        end
                    end
                    RUN: begin
                        // any redirect, legal or not, swallows a coincident halt
                        if (redirect_i && legal) begin
                            pc_q  <= redirect_target_i;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end else if (redirect_i) begin
                            mis_q      <= 1'b1;
                            mis_addr_q <= redirect_target_i;
                        end else if (halt_i) begin
                            state_q <= HALT;
                            valid_q <= 1'b0;
                        end else if (!stall_i) begin
                            pc_q  <= pc_plus_o;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    HALT: begin
                        if (resume_i) begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= BOOT;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: randomized and directed checks of two pc_gen_unit configurations against a behavioural model.
module tb_pc_gen_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0, is_compressed_i = 1'b0, redirect_i = 1'b0;
    logic        trap_i = 1'b0, halt_i = 1'b0, resume_i = 1'b0;
    logic [31:0] redirect_target_i = '0, trap_vector_i = '0;

    logic [31:0] pc_w [2];
    logic [31:0] plus_w [2];
    logic [31:0] maddr_w [2];
    logic        valid_w [2];
    logic        mis_w [2];
    logic [31:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_tests = 0;
    int n_fail = 0;

    // instance 0: C enabled, 32-bit counter; instance 1: C disabled, 2-bit counter
    int          p_wait [2] = '{2, 1};
    bit          p_c [2]    = '{1'b1, 1'b0};
    longint      p_cmod [2] = '{64'h1_0000_0000, 64'd4};

    logic [31:0] m_pc [2];
    logic [31:0] m_maddr [2];
    int          m_mode [2];
    int          m_elapsed [2];
    longint      m_cnt [2];
    bit          m_mis [2];

    always #5 clk = ~clk;

    pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h1000), .BOOT_WAIT(2), .ALLOW_C(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .is_compressed_i(is_compressed_i),
        .redirect_i(redirect_i), .redirect_target_i(redirect_target_i), .trap_i(trap_i),
        .trap_vector_i(trap_vector_i), .halt_i(halt_i), .resume_i(resume_i),
        .pc_o(pc_w[0]), .pc_plus_o(plus_w[0]), .pc_valid_o(valid_w[0]), .misaligned_o(mis_w[0]),
        .misaligned_addr_o(maddr_w[0]), .fetch_count_o(cnt_a));

    pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h1000), .BOOT_WAIT(1), .ALLOW_C(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .is_compressed_i(is_compressed_i),
        .redirect_i(redirect_i), .redirect_target_i(redirect_target_i), .trap_i(trap_i),
        .trap_vector_i(trap_vector_i), .halt_i(halt_i), .resume_i(resume_i),
        .pc_o(pc_w[1]), .pc_plus_o(plus_w[1]), .pc_valid_o(valid_w[1]), .misaligned_o(mis_w[1]),
        .misaligned_addr_o(maddr_w[1]), .fetch_count_o(cnt_b));

    // modes: 0 = BOOT, 1 = RUN, 2 = HALT
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h1000; m_maddr[k] = '0; m_mode[k] = 0;
            m_elapsed[k] = 0; m_cnt[k] = 0; m_mis[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            longint step = (p_c[k] && is_compressed_i) ? 2 : 4;
            longint align = p_c[k] ? 2 : 4;
            bit adv = 1'b0;
            m_mis[k] = 1'b0;
            if (trap_i) begin
                m_pc[k] = trap_vector_i & ~32'h3; adv = 1'b1; m_mode[k] = 1;
            end else if (m_mode[k] == 0) begin
                m_elapsed[k]++;
                if (m_elapsed[k] >= p_wait[k]) m_mode[k] = 1;
            end else if (m_mode[k] == 1) begin
                if (redirect_i && (longint'(redirect_target_i) % align == 0)) begin
                    m_pc[k] = redirect_target_i; adv = 1'b1;
                end else if (redirect_i) begin
                    m_mis[k] = 1'b1; m_maddr[k] = redirect_target_i;
                end else if (halt_i) begin
                    m_mode[k] = 2;
                end else if (!stall_i) begin
                    m_pc[k] = 32'((longint'(m_pc[k]) + step) % 64'h1_0000_0000); adv = 1'b1;
                end
            end else if (resume_i) begin
                m_mode[k] = 1;
            end
            if (adv) m_cnt[k] = (m_cnt[k] + 1) % p_cmod[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 0; is_compressed_i = 0; redirect_i = 0; trap_i = 0; halt_i = 0; resume_i = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #7;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (pc_w[k] !== 32'h1000 || valid_w[k] !== 1'b0 || mis_w[k] !== 1'b0 || maddr_w[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset%0d: pc=%h valid=%b mis=%b maddr=%h exp pc=00001000 valid=0 mis=0 maddr=0",
                         k, pc_w[k], valid_w[k], mis_w[k], maddr_w[k]);
            end
        end
        n_tests++;
        if (cnt_a !== 32'd0 || cnt_b !== 2'd0) begin
            n_fail++; $display("FAIL reset_cnt: a=%0d b=%0d exp 0 0", cnt_a, cnt_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (valid_w[0] !== 1'b0 || valid_w[1] !== 1'b1) begin
            n_fail++; $display("FAIL boot_cycle1: valid a=%b b=%b exp 0 1", valid_w[0], valid_w[1]);
        end
        tick();
        n_tests++;
        if (valid_w[0] !== 1'b1 || pc_w[0] !== 32'h1000) begin
            n_fail++; $display("FAIL boot_done: valid=%b pc=%h exp 1 00001000", valid_w[0], pc_w[0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (pc_w[0] !== m_pc[0] || cnt_a !== 32'(m_cnt[0]) || pc_w[1] !== m_pc[1] || cnt_b !== 2'(m_cnt[1])) begin
                n_fail++;
                $display("FAIL seq_inc%0d: pc a=%h b=%h cnt a=%0d b=%0d exp pc %h %h cnt %0d %0d",
                         i, pc_w[0], pc_w[1], cnt_a, cnt_b, m_pc[0], m_pc[1], m_cnt[0], m_cnt[1] % 4);
            end
        end
    endtask

    task automatic test_compressed();
        redirect_i = 1; redirect_target_i = 32'h2000;
        tick();
        redirect_i = 0; is_compressed_i = 1;
        #1;
        n_tests++;
        if (plus_w[0] !== 32'h2002 || plus_w[1] !== 32'h2004) begin
            n_fail++; $display("FAIL pc_plus: a=%h b=%h exp 00002002 00002004", plus_w[0], plus_w[1]);
        end
        tick();
        is_compressed_i = 0;
        tick();
        n_tests++;
        if (pc_w[0] !== 32'h2006 || pc_w[1] !== 32'h2008 || pc_w[0] !== m_pc[0] || pc_w[1] !== m_pc[1]) begin
            n_fail++; $display("FAIL compressed: a=%h b=%h exp 00002006 00002008", pc_w[0], pc_w[1]);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] held [2];
        held[0] = pc_w[0]; held[1] = pc_w[1];
        redirect_i = 1; stall_i = 1; redirect_target_i = 32'h3001;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (pc_w[k] !== held[k] || mis_w[k] !== 1'b1 || maddr_w[k] !== 32'h3001) begin
                n_fail++; $display("FAIL mis_reject%0d: pc=%h mis=%b maddr=%h exp %h 1 00003001",
                                   k, pc_w[k], mis_w[k], maddr_w[k], held[k]);
            end
        end
        redirect_target_i = 32'h3000;
        tick();
        n_tests++;
        if (pc_w[0] !== 32'h3000 || pc_w[1] !== 32'h3000 || mis_w[0] !== 1'b0 || mis_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL redir_stall: pc %h %h mis %b %b exp 00003000 0", pc_w[0], pc_w[1], mis_w[0], mis_w[1]);
        end
        redirect_target_i = 32'h3002;
        tick();
        n_tests++;
        if (pc_w[0] !== 32'h3002 || pc_w[1] !== 32'h3000 || mis_w[0] !== 1'b0 || mis_w[1] !== 1'b1) begin
            n_fail++; $display("FAIL half_align: pc %h %h mis %b %b exp 00003002 00003000 0 1", pc_w[0], pc_w[1], mis_w[0], mis_w[1]);
        end
        redirect_target_i = 32'h3005;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (mis_w[0] !== 1'b1 || mis_w[1] !== 1'b1 || maddr_w[0] !== 32'h3005) begin
                n_fail++; $display("FAIL b2b_reject%0d: mis %b %b maddr %h exp 1 1 00003005", i, mis_w[0], mis_w[1], maddr_w[0]);
            end
        end
        clear_inputs();
        tick();
        n_tests++;
        if (mis_w[0] !== 1'b0 || mis_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL mis_pulse_end: mis %b %b exp 0 0", mis_w[0], mis_w[1]);
        end
    endtask

    task automatic test_trap_priority();
        trap_i = 1; trap_vector_i = 32'h8003; redirect_i = 1; redirect_target_i = 32'h4001; halt_i = 1;
        tick();
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (pc_w[k] !== 32'h8000 || valid_w[k] !== 1'b1 || mis_w[k] !== 1'b0) begin
                n_fail++; $display("FAIL trap_prio%0d: pc=%h valid=%b mis=%b exp 00008000 1 0", k, pc_w[k], valid_w[k], mis_w[k]);
            end
        end
    endtask

    task automatic test_halt();
        logic [31:0] frozen [2];
        halt_i = 1;
        tick();
        frozen[0] = pc_w[0]; frozen[1] = pc_w[1];
        halt_i = 0; redirect_i = 1; redirect_target_i = 32'h5000;
        for (int i = 0; i < 5; i++) begin
            stall_i = 1'($urandom_range(0, 1));
            tick();
            n_tests++;
            if (valid_w[0] !== 1'b0 || valid_w[1] !== 1'b0 || pc_w[0] !== frozen[0] || pc_w[1] !== frozen[1]) begin
                n_fail++; $display("FAIL halt_hold%0d: valid %b %b pc %h %h exp 0 0 %h %h",
                                   i, valid_w[0], valid_w[1], pc_w[0], pc_w[1], frozen[0], frozen[1]);
            end
        end
        clear_inputs();
        halt_i = 1; resume_i = 1;
        tick();
        clear_inputs();
        n_tests++;
        if (valid_w[0] !== 1'b1 || pc_w[0] !== frozen[0] || pc_w[1] !== frozen[1]) begin
            n_fail++; $display("FAIL resume: valid=%b pc %h %h exp 1 %h %h", valid_w[0], pc_w[0], pc_w[1], frozen[0], frozen[1]);
        end
        tick();
        n_tests++;
        if (pc_w[0] !== frozen[0] + 32'd4 || pc_w[1] !== m_pc[1]) begin
            n_fail++; $display("FAIL post_resume: pc %h exp %h", pc_w[0], frozen[0] + 32'd4);
        end
    endtask

    task automatic test_wrap();
        redirect_i = 1; redirect_target_i = 32'hFFFF_FFFC;
        for (int i = 0; i < 8 && !(m_cnt[1] % 4 == 3 && m_pc[1] == 32'hFFFF_FFFC); i++) tick();
        clear_inputs();
        n_tests++;
        if (cnt_b !== 2'd3 || pc_w[1] !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_setup: cnt=%0d pc=%h exp 3 fffffffc", cnt_b, pc_w[1]);
        end
        tick();
        n_tests++;
        if (pc_w[0] !== 32'h0 || pc_w[1] !== 32'h0 || cnt_b !== 2'd0 || cnt_a !== 32'(m_cnt[0])) begin
            n_fail++; $display("FAIL wrap: pc %h %h cnt_b %0d cnt_a %0d exp 0 0 0 %0d", pc_w[0], pc_w[1], cnt_b, cnt_a, m_cnt[0]);
        end
        redirect_i = 1; redirect_target_i = 32'h6000;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (pc_w[k] !== 32'h1000 || valid_w[k] !== 1'b0 || mis_w[k] !== 1'b0 || maddr_w[k] !== 32'h0) begin
                n_fail++; $display("FAIL async_reset%0d: pc=%h valid=%b mis=%b maddr=%h exp 00001000 0 0 0",
                                   k, pc_w[k], valid_w[k], mis_w[k], maddr_w[k]);
            end
        end
        n_tests++;
        if (cnt_a !== 32'd0 || cnt_b !== 2'd0) begin
            n_fail++; $display("FAIL async_reset_cnt: a=%0d b=%0d exp 0 0", cnt_a, cnt_b);
        end
        @(posedge clk); #1;
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            trap_i = ($urandom_range(0, 15) == 0);
            trap_vector_i = $urandom;
            redirect_i = ($urandom_range(0, 3) == 0);
            redirect_target_i = $urandom;
            stall_i = ($urandom_range(0, 3) == 0);
            halt_i = ($urandom_range(0, 7) == 0);
            resume_i = ($urandom_range(0, 2) == 0);
            is_compressed_i = 1'($urandom_range(0, 1));
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (plus_w[k] !== m_pc[k] + ((p_c[k] && is_compressed_i) ? 32'd2 : 32'd4)) begin
                    n_fail++; $display("FAIL rnd_plus%0d @%0d: got %h pc %h", k, i, plus_w[k], m_pc[k]);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (pc_w[k] !== m_pc[k] || valid_w[k] !== (m_mode[k] == 1) || mis_w[k] !== m_mis[k] || maddr_w[k] !== m_maddr[k]) begin
                    n_fail++; $display("FAIL rnd_state%0d @%0d: pc=%h valid=%b mis=%b maddr=%h exp %h %b %b %h",
                                       k, i, pc_w[k], valid_w[k], mis_w[k], maddr_w[k], m_pc[k], m_mode[k] == 1, m_mis[k], m_maddr[k]);
                end
            end
            n_tests++;
            if (cnt_a !== 32'(m_cnt[0]) || cnt_b !== 2'(m_cnt[1])) begin
                n_fail++; $display("FAIL rnd_cnt @%0d: a=%0d b=%0d exp %0d %0d", i, cnt_a, cnt_b, m_cnt[0], m_cnt[1]);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_compressed();
        test_misaligned();
        test_trap_priority();
        test_halt();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
